// File: rtl/sram_mem_responder.sv
// sram_mem_responder
// Serves 32-bit MEM-stage word requests over a 16-bit external SRAM bus.
// Each word takes two halfword phases: low half first, then high half.
// ready is the pipeline freeze signal and stays low until the access completes.
module sram_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          WAIT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n
);

  localparam int            CW   = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          is_write;
  logic          is_write_next;
  logic          req;
  logic          phase_last;
  logic [31:0]   offset;
  logic [16:0]   word;
  logic          unused_offset;

  // The request address is held stable by the pipeline until ready, so the
  // SRAM word index is derived directly from it; bits [1:0] are byte lanes.
  assign req           = rd_en | wr_en;
  assign offset        = address - BASE_ADDR;
  assign word          = offset[18:2];
  assign unused_offset = ^{offset[31:19], offset[1:0]};
  assign phase_last    = (cnt == LAST);

  // State register: FSM state, per-phase wait counter and latched access type
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      is_write <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      is_write <= is_write_next;
    end
  end

  // Next-state logic: each halfword phase lasts WAIT_CYCLES cycles, counter wraps per phase
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    is_write_next = is_write;
    case (state)
      IDLE: begin
        if (req) begin
          state_next    = LOW;
          cnt_next      = '0;
          is_write_next = wr_en;
        end
      end
      LOW: begin
        if (phase_last) begin
          state_next = HIGH;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      HIGH: begin
        if (phase_last) begin
          state_next = DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Output decode: bus signals follow the state so reset clears them at once
  always_comb begin
    ready       = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    case (state)
      IDLE: begin
        ready = ~req;
      end
      LOW: begin
        sram_addr = {word, 1'b0};
        if (is_write) begin
          sram_dq_out = write_data[15:0];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
      end
      HIGH: begin
        sram_addr = {word, 1'b1};
        if (is_write) begin
          sram_dq_out = write_data[31:16];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
      end
      DONE: begin
        ready = 1'b1;
      end
      default: begin
        ready = 1'b0;
      end
    endcase
  end

  // Read capture: each halfword is sampled on the final cycle of its phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data <= '0;
    end else if (!is_write && phase_last) begin
      if (state == LOW) begin
        read_data[15:0] <= sram_dq_in;
      end else if (state == HIGH) begin
        read_data[31:16] <= sram_dq_in;
      end
    end
  end

endmodule

// File: tb/tb_sram_mem_responder.sv
// tb_sram_mem_responder
// Drives two responders (default wait and single-cycle wait) against simple
// SRAM device models; a transaction-level model checks the default instance
// every cycle and directed sequences pin specific values.
`timescale 1ns/1ps
module tb_sram_mem_responder;

  localparam int          WA   = 3;
  localparam int          WB   = 1;
  localparam logic [31:0] BASE = 32'd1024;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        rd_a = 1'b0, wr_a = 1'b0;
  logic [31:0] addr_a = '0, wdata_a = '0;
  logic [31:0] rdata_a;
  logic        ready_a;
  logic [17:0] saddr_a;
  logic [15:0] sdo_a, sdi_a;
  logic        oe_a, we_n_a;

  logic        rd_b = 1'b0, wr_b = 1'b0;
  logic [31:0] addr_b = '0, wdata_b = '0;
  logic [31:0] rdata_b;
  logic        ready_b;
  logic [17:0] saddr_b;
  logic [15:0] sdo_b, sdi_b;
  logic        oe_b, we_n_b;

  logic [15:0] sram_a [0:262143];
  logic [15:0] sram_b [0:262143];
  logic [31:0] model_mem [0:131071];

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model state for instance A
  bit          m_busy = 1'b0;
  int          m_k    = 0;
  bit          m_write = 1'b0;
  logic [16:0] m_word = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_rdata = '0;

  always #5 clk = ~clk;

  sram_mem_responder #(.BASE_ADDR(BASE), .WAIT_CYCLES(WA)) dut_a (
    .clk(clk), .rst(rst), .rd_en(rd_a), .wr_en(wr_a), .address(addr_a),
    .write_data(wdata_a), .read_data(rdata_a), .ready(ready_a),
    .sram_addr(saddr_a), .sram_dq_out(sdo_a), .sram_dq_oe(oe_a),
    .sram_dq_in(sdi_a), .sram_we_n(we_n_a)
  );

  sram_mem_responder #(.BASE_ADDR(BASE), .WAIT_CYCLES(WB)) dut_b (
    .clk(clk), .rst(rst), .rd_en(rd_b), .wr_en(wr_b), .address(addr_b),
    .write_data(wdata_b), .read_data(rdata_b), .ready(ready_b),
    .sram_addr(saddr_b), .sram_dq_out(sdo_b), .sram_dq_oe(oe_b),
    .sram_dq_in(sdi_b), .sram_we_n(we_n_b)
  );

  // Asynchronous-read SRAM devices with write on the clock edge while we_n is low
  assign sdi_a = sram_a[saddr_a];
  assign sdi_b = sram_b[saddr_b];

  always @(posedge clk) begin
    if (!we_n_a) sram_a[saddr_a] <= sdo_a;
    if (!we_n_b) sram_b[saddr_b] <= sdo_b;
  end

  initial begin
    for (int i = 0; i < 262144; i++) begin
      sram_a[i] = '0;
      sram_b[i] = '0;
    end
    for (int i = 0; i < 131072; i++) model_mem[i] = '0;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Per-cycle comparison of instance A against a cycle-index model of one access
  always @(negedge clk) begin
    logic [31:0] off;
    logic        hi;
    logic        exp_ready;
    int          done_k;
    done_k = 2 * WA + 1;
    if (rst) begin
      m_busy  = 1'b0;
      m_k     = 0;
      m_rdata = '0;
      checkOutput("rst_we_n", {31'd0, we_n_a}, 32'd1);
      checkOutput("rst_oe", {31'd0, oe_a}, 32'd0);
      checkOutput("rst_read_data", rdata_a, 32'd0);
      checkOutput("rst_sram_addr", {14'd0, saddr_a}, 32'd0);
      checkOutput("rst_dq_out", {16'd0, sdo_a}, 32'd0);
    end else begin
      if (!m_busy && (rd_a || wr_a)) begin
        m_busy  = 1'b1;
        m_k     = 0;
        m_write = wr_a;
        off     = addr_a - BASE;
        m_word  = off[18:2];
        m_wdata = wdata_a;
      end
      if (m_busy && m_k == done_k) begin
        if (m_write) model_mem[m_word] = m_wdata;
        else         m_rdata = model_mem[m_word];
      end
      exp_ready = !m_busy || (m_k == done_k);
      checkOutput("ready", {31'd0, ready_a}, {31'd0, exp_ready});
      if (m_busy && m_k >= 1 && m_k <= 2 * WA) begin
        hi = (m_k > WA);
        checkOutput("sram_addr", {14'd0, saddr_a}, {14'd0, m_word, hi});
        checkOutput("dq_oe", {31'd0, oe_a}, {31'd0, m_write});
        checkOutput("we_n", {31'd0, we_n_a}, {31'd0, !m_write});
        if (m_write)
          checkOutput("dq_out", {16'd0, sdo_a}, {16'd0, hi ? m_wdata[31:16] : m_wdata[15:0]});
      end else begin
        checkOutput("dq_oe_quiet", {31'd0, oe_a}, 32'd0);
        checkOutput("we_n_quiet", {31'd0, we_n_a}, 32'd1);
      end
      if (!m_busy || m_k == 0 || m_k == done_k)
        checkOutput("read_data", rdata_a, m_rdata);
      if (m_busy) begin
        if (m_k == done_k) m_busy = 1'b0;
        else               m_k++;
      end
    end
  end

  function automatic logic curReady(input bit sel);
    return sel ? ready_b : ready_a;
  endfunction

  function automatic logic [17:0] curAddr(input bit sel);
    return sel ? saddr_b : saddr_a;
  endfunction

  function automatic logic curWeN(input bit sel);
    return sel ? we_n_b : we_n_a;
  endfunction

  task automatic applyStimulus(input bit sel, input bit wr, input bit rd,
                               input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk);
    #1;
    if (sel) begin
      wr_b = wr; rd_b = rd; addr_b = addr; wdata_b = data;
    end else begin
      wr_a = wr; rd_a = rd; addr_a = addr; wdata_a = data;
    end
  endtask

  // Presents a request and follows it to its DONE cycle, counting cycles from 0
  task automatic runAccess(input bit sel, input bit wr, input bit rd,
                           input logic [31:0] addr, input logic [31:0] data,
                           output int lat, output logic [17:0] a_lo,
                           output logic [17:0] a_hi, output bit we_seen);
    int w;
    w = sel ? WB : WA;
    applyStimulus(sel, wr, rd, addr, data);
    #1;
    lat = 0; a_lo = '0; a_hi = '0; we_seen = 1'b0;
    while (!curReady(sel) && lat < 100) begin
      @(posedge clk);
      #2;
      lat++;
      if (lat == 1)     a_lo = curAddr(sel);
      if (lat == w + 1) a_hi = curAddr(sel);
      if (!curWeN(sel)) we_seen = 1'b1;
    end
  endtask

  task automatic idleInputs(input bit sel);
    applyStimulus(sel, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          lat;
    logic [17:0] a_lo, a_hi;
    bit          we_seen;

    // Reset state
    @(posedge clk);
    #2;
    checkOutput("reset_ready", {31'd0, ready_a}, 32'd1);
    checkOutput("reset_we_n", {31'd0, we_n_a}, 32'd1);
    checkOutput("reset_read_data", rdata_a, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Write then read DEADBEEF at the base address
    runAccess(0, 1, 0, 32'd1024, 32'hDEADBEEF, lat, a_lo, a_hi, we_seen);
    checkOutput("wr_latency", lat, 32'd7);
    checkOutput("wr_we_seen", {31'd0, we_seen}, 32'd1);
    idleInputs(0);
    checkOutput("sram_lo_half", {16'd0, sram_a[0]}, 32'h0000BEEF);
    checkOutput("sram_hi_half", {16'd0, sram_a[1]}, 32'h0000DEAD);
    runAccess(0, 0, 1, 32'd1024, 32'd0, lat, a_lo, a_hi, we_seen);
    checkOutput("rd_latency", lat, 32'd7);
    checkOutput("rd_data", rdata_a, 32'hDEADBEEF);
    checkOutput("rd_no_write", {31'd0, we_seen}, 32'd0);
    idleInputs(0);

    // Address mapping: word 300, with and without byte-offset bits
    runAccess(0, 1, 0, 32'd2224, 32'hCAFEF00D, lat, a_lo, a_hi, we_seen);
    checkOutput("map_lo", {14'd0, a_lo}, 32'd600);
    checkOutput("map_hi", {14'd0, a_hi}, 32'd601);
    idleInputs(0);
    runAccess(0, 0, 1, 32'd2227, 32'd0, lat, a_lo, a_hi, we_seen);
    checkOutput("map11_lo", {14'd0, a_lo}, 32'd600);
    checkOutput("map11_hi", {14'd0, a_hi}, 32'd601);
    checkOutput("map11_data", rdata_a, 32'hCAFEF00D);
    idleInputs(0);

    // Simultaneous read and write requests resolve to a write
    runAccess(0, 1, 1, 32'd1028, 32'h12345678, lat, a_lo, a_hi, we_seen);
    checkOutput("both_we_seen", {31'd0, we_seen}, 32'd1);
    checkOutput("both_rdata_kept", rdata_a, 32'hCAFEF00D);
    idleInputs(0);
    checkOutput("both_sram_lo", {16'd0, sram_a[2]}, 32'h00005678);
    checkOutput("both_sram_hi", {16'd0, sram_a[3]}, 32'h00001234);

    // Back-to-back write then read with no idle gap
    runAccess(0, 1, 0, 32'd1028, 32'h0BADF00D, lat, a_lo, a_hi, we_seen);
    checkOutput("b2b_wr_latency", lat, 32'd7);
    runAccess(0, 0, 1, 32'd1028, 32'd0, lat, a_lo, a_hi, we_seen);
    checkOutput("b2b_rd_latency", lat, 32'd7);
    checkOutput("b2b_rd_data", rdata_a, 32'h0BADF00D);
    idleInputs(0);

    // Reset pulse during the high phase of a write
    applyStimulus(0, 1, 0, 32'd1064, 32'h55AA33CC);
    repeat (4) @(posedge clk);
    #2;
    checkOutput("pre_rst_we_n", {31'd0, we_n_a}, 32'd0);
    #1;
    wr_a = 1'b0;
    rst  = 1'b1;
    #1;
    checkOutput("async_rst_we_n", {31'd0, we_n_a}, 32'd1);
    checkOutput("async_rst_oe", {31'd0, oe_a}, 32'd0);
    checkOutput("async_rst_rdata", rdata_a, 32'd0);
    checkOutput("async_rst_addr", {14'd0, saddr_a}, 32'd0);
    checkOutput("async_rst_ready", {31'd0, ready_a}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("post_rst_ready", {31'd0, ready_a}, 32'd1);
    runAccess(0, 0, 1, 32'd1024, 32'd0, lat, a_lo, a_hi, we_seen);
    checkOutput("post_rst_rd_data", rdata_a, 32'hDEADBEEF);
    idleInputs(0);

    // Single-cycle wait instance
    runAccess(1, 1, 0, 32'd1044, 32'h22221111, lat, a_lo, a_hi, we_seen);
    checkOutput("w1_wr_latency", lat, 32'd3);
    idleInputs(1);
    checkOutput("w1_sram_lo", {16'd0, sram_b[10]}, 32'h00001111);
    checkOutput("w1_sram_hi", {16'd0, sram_b[11]}, 32'h00002222);
    runAccess(1, 0, 1, 32'd1044, 32'd0, lat, a_lo, a_hi, we_seen);
    checkOutput("w1_rd_latency", lat, 32'd3);
    checkOutput("w1_addr_cycle1", {14'd0, a_lo}, 32'd10);
    checkOutput("w1_addr_cycle2", {14'd0, a_hi}, 32'd11);
    checkOutput("w1_rd_data", rdata_b, 32'h22221111);
    idleInputs(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
